// File: rtl/rr_mem_server_pkg.sv
// rtl/rr_mem_server_pkg.sv - shared state encoding and request-word field helpers
// Optional feature macro: RR_MEM_SERVER_INTERP_EN (linear interpolation between adjacent entries)
package rr_mem_server_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE_A = 3'd1,
    S_ISSUE_B = 3'd2,
    S_WAIT    = 3'd3,
    S_CALC    = 3'd4,
    S_RESP    = 3'd5
  } state_t;

`ifdef RR_MEM_SERVER_INTERP_EN
  localparam bit INTERP_EN = 1'b1;
`else
  localparam bit INTERP_EN = 1'b0;
`endif

  // Bit position of the table index inside the request word; the fraction sits below it
  function automatic int idx_lsb(input int frac_bits);
    return INTERP_EN ? frac_bits : 0;
  endfunction

endpackage

// File: rtl/rr_mem_server_ram.sv
// rtl/rr_mem_server_ram.sv - simple dual-port inferred RAM with a configurable read pipeline
module rr_mem_server_ram #(
  parameter int data_width = 16,
  parameter int addr_width = 12,
  parameter int latency    = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_en,
  input  logic [addr_width-1:0] i_wr_addr,
  input  logic [data_width-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [addr_width-1:0] i_rd_addr,
  input  logic                  i_rd_tag,
  output logic [data_width-1:0] o_rd_data,
  output logic                  o_rd_valid,
  output logic                  o_rd_tag
);

  logic [data_width-1:0] r_mem [2**addr_width];
  logic [data_width-1:0] r_q   [latency];
  logic [latency-1:0]    r_v;
  logic [latency-1:0]    r_t;

  // Write port; contents are never cleared
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Read data pipeline, left without reset so it maps onto the RAM output registers
  always_ff @(posedge i_clk) begin
    if (i_rd_en) r_q[0] <= r_mem[i_rd_addr];
    for (int i = 1; i < latency; i++) r_q[i] <= r_q[i-1];
  end

  // Valid/tag pipeline tracking which issued read is currently on the output
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_v <= '0;
      r_t <= '0;
    end else begin
      r_v[0] <= i_rd_en;
      r_t[0] <= i_rd_tag;
      for (int i = 1; i < latency; i++) begin
        r_v[i] <= r_v[i-1];
        r_t[i] <= r_t[i-1];
      end
    end
  end

  assign o_rd_data  = r_q[latency-1];
  assign o_rd_valid = r_v[latency-1];
  assign o_rd_tag   = r_t[latency-1];

endmodule

// File: rtl/rr_mem_server.sv
// rtl/rr_mem_server.sv - arbitrated table-lookup responder with runtime-loadable tables
// Optional feature macro: RR_MEM_SERVER_INTERP_EN (interpolate between entry idx and idx+1)
module rr_mem_server
  import rr_mem_server_pkg::*;
#(
  parameter int req_data_width    = 16,
  parameter int handle_width      = 8,
  parameter int server_data_width = 16,
  parameter int addr_width        = 10,
  parameter int n_tables          = 4,
  parameter int frac_bits         = 6,
  parameter int mem_latency       = 1,
  parameter int tsel_width        = (n_tables > 1) ? $clog2(n_tables) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             arbiter_req,
  input  logic [req_data_width-1:0]        arbiter_req_data,
  input  logic [handle_width-1:0]          arbiter_req_handle,
  output logic [server_data_width-1:0]     server_data,
  output logic                             server_ready,
  input  logic                             wr_en,
  input  logic [tsel_width+addr_width-1:0] wr_addr,
  input  logic [server_data_width-1:0]     wr_data,
  output logic                             busy,
  output logic                             proto_err
);

  localparam int IDX_LSB = idx_lsb(frac_bits);
  localparam int CNT_W   = (mem_latency > 1) ? $clog2(mem_latency) : 1;
  localparam int SDW     = server_data_width;
  localparam int RAM_AW  = tsel_width + addr_width;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [addr_width-1:0] r_idx;
  logic [tsel_width-1:0] r_tsel;
  logic [CNT_W-1:0]      r_cnt;
  logic [SDW-1:0]        r_res;
  logic [SDW-1:0]        r_server_data;
  logic                  r_server_ready;
  logic                  r_proto_err;

  logic                  w_rd_en;
  logic                  w_rd_tag;
  logic [RAM_AW-1:0]     w_rd_addr;
  logic [SDW-1:0]        w_rd_q;
  logic                  w_q_valid;
  logic                  w_q_tag;
  logic                  w_handle_bad;
  logic                  w_wait_done;
  logic                  w_unused;

  assign w_handle_bad = 32'(arbiter_req_handle) >= 32'(n_tables);
  assign w_wait_done  = (r_cnt == CNT_W'(mem_latency - 1));

`ifdef RR_MEM_SERVER_INTERP_EN
  localparam int PW = SDW + frac_bits + 2;

  logic [frac_bits-1:0]  r_frac;
  logic [SDW-1:0]        r_a;
  logic [SDW-1:0]        r_b;
  logic [addr_width-1:0] w_idx_b;
  logic signed [SDW:0]   w_diff;
  logic signed [frac_bits:0] w_frac_s;
  logic signed [PW-1:0]  w_prod;
  logic signed [PW-1:0]  w_shift;
  logic [SDW-1:0]        w_calc;
  logic                  w_unused_calc;

  assign w_idx_b       = r_idx + addr_width'(1);
  assign w_diff        = $signed({r_b[SDW-1], r_b}) - $signed({r_a[SDW-1], r_a});
  assign w_frac_s      = $signed({1'b0, r_frac});
  assign w_prod        = PW'(w_diff) * PW'(w_frac_s);
  assign w_shift       = w_prod >>> frac_bits;
  assign w_calc        = r_a + w_shift[SDW-1:0];
  assign w_unused_calc = &{1'b0, w_shift[PW-1:SDW]};

  // Interpolation operands: a arrives on the untagged read, b on the tagged one
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frac <= '0;
      r_a    <= '0;
      r_b    <= '0;
    end else begin
      if ((r_state == S_IDLE) && arbiter_req) r_frac <= arbiter_req_data[frac_bits-1:0];
      if (w_q_valid && !w_q_tag) r_a <= w_rd_q;
      if (w_q_valid && w_q_tag)  r_b <= w_rd_q;
    end
  end
`endif

  assign w_unused = &{1'b0, arbiter_req_data, w_q_valid, w_q_tag};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and RAM read issue; a loader write in an issue cycle stalls the read
  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    w_rd_tag    = 1'b0;
    w_rd_addr   = {r_tsel, r_idx};
    case (r_state)
      S_IDLE: begin
        if (arbiter_req) w_state_nxt = w_handle_bad ? S_RESP : S_ISSUE_A;
      end
      S_ISSUE_A: begin
        if (!wr_en) begin
          w_rd_en     = 1'b1;
          w_state_nxt = INTERP_EN ? S_ISSUE_B : S_WAIT;
        end
      end
`ifdef RR_MEM_SERVER_INTERP_EN
      S_ISSUE_B: begin
        w_rd_addr = {r_tsel, w_idx_b};
        if (!wr_en) begin
          w_rd_en     = 1'b1;
          w_rd_tag    = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_CALC: w_state_nxt = S_RESP;
`endif
      S_WAIT: begin
        if (w_wait_done) w_state_nxt = INTERP_EN ? S_CALC : S_RESP;
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request capture, result capture, response registers and sticky protocol error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx          <= '0;
      r_tsel         <= '0;
      r_cnt          <= '0;
      r_res          <= '0;
      r_server_data  <= '0;
      r_server_ready <= 1'b0;
      r_proto_err    <= 1'b0;
    end else begin
      r_server_ready <= 1'b0;
      if (arbiter_req && (r_state != S_IDLE)) r_proto_err <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (arbiter_req) begin
            r_idx  <= arbiter_req_data[IDX_LSB +: addr_width];
            r_tsel <= arbiter_req_handle[tsel_width-1:0];
            r_cnt  <= '0;
            r_res  <= '0;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_wait_done && !INTERP_EN) r_res <= w_rd_q;
        end
`ifdef RR_MEM_SERVER_INTERP_EN
        S_CALC: r_res <= w_calc;
`endif
        S_RESP: begin
          r_server_data  <= r_res;
          r_server_ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  rr_mem_server_ram #(
    .data_width (SDW),
    .addr_width (RAM_AW),
    .latency    (mem_latency)
  ) u_ram (
    .i_clk      (clk),
    .i_rst      (reset),
    .i_wr_en    (wr_en),
    .i_wr_addr  (wr_addr),
    .i_wr_data  (wr_data),
    .i_rd_en    (w_rd_en),
    .i_rd_addr  (w_rd_addr),
    .i_rd_tag   (w_rd_tag),
    .o_rd_data  (w_rd_q),
    .o_rd_valid (w_q_valid),
    .o_rd_tag   (w_q_tag)
  );

  assign server_data  = r_server_data;
  assign server_ready = r_server_ready;
  assign busy         = (r_state != S_IDLE);
  assign proto_err    = r_proto_err;

endmodule

// File: tb/tb_rr_mem_server.sv
// tb/tb_rr_mem_server.sv - randomized self-checking bench for rr_mem_server against a table model
module tb_rr_mem_server;

  localparam int ML = 1;
  localparam int AW = 10;
  localparam int NT = 4;
  localparam int FB = 6;
`ifdef RR_MEM_SERVER_INTERP_EN
  localparam bit INTERP = 1'b1;
`else
  localparam bit INTERP = 1'b0;
`endif
  localparam int BASE_L = INTERP ? ML + 4 : ML + 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        arbiter_req = 1'b0;
  logic [15:0] req_data = '0;
  logic [7:0]  req_handle = '0;
  logic [15:0] server_data;
  logic        server_ready;
  logic        wr_en = 1'b0;
  logic [11:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        busy;
  logic        proto_err;

  logic [15:0] mdl [4096];
  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  rr_mem_server #(
    .req_data_width(16), .handle_width(8), .server_data_width(16), .addr_width(AW),
    .n_tables(NT), .frac_bits(FB), .mem_latency(ML)
  ) dut (
    .clk(clk), .reset(reset), .arbiter_req(arbiter_req),
    .arbiter_req_data(req_data), .arbiter_req_handle(req_handle),
    .server_data(server_data), .server_ready(server_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .proto_err(proto_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Response the table service should give, from the table contents and the request word
  function automatic logic [15:0] ref_result(input logic [7:0] h, input logic [15:0] d);
    int t, ia, ib, fr, a, b, q;
    if (int'(h) >= NT) return 16'h0000;
    t = int'(h);
    if (!INTERP) return mdl[t * 1024 + (int'(d) % 1024)];
    ia = (int'(d) / 64) % 1024;
    fr = int'(d) % 64;
    ib = (ia + 1) % 1024;
    a  = int'($signed(mdl[t * 1024 + ia]));
    b  = int'($signed(mdl[t * 1024 + ib]));
    q  = ((b - a) * fr) >>> FB;
    return 16'(a + q);
  endfunction

  task automatic load(input logic [11:0] a, input logic [15:0] v);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = v;
    mdl[a]  = v;
  endtask

  task automatic txn(input string tag, input logic [7:0] h, input logic [15:0] d, input int stalls,
                     input logic [11:0] waddr, input logic [15:0] wdata, input bit drop2);
    logic [15:0] exp_d;
    int exp_l, cyc, lat;
    bit got;
    exp_d = ref_result(h, d);
    exp_l = (int'(h) >= NT) ? 1 : BASE_L + stalls;
    @(negedge clk);
    arbiter_req = 1'b1;
    req_handle  = h;
    req_data    = d;
    @(posedge clk);
    cyc = 0; got = 1'b0; lat = 0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      arbiter_req = drop2 && (cyc == 2);
      if (arbiter_req) begin
        req_handle = h ^ 8'h01;
        req_data   = ~d;
      end
      wr_en = (cyc <= stalls);
      if (wr_en) begin
        wr_addr    = waddr;
        wr_data    = wdata;
        mdl[waddr] = wdata;
      end
      if (cyc == 1 && int'(h) < NT) check_eq({tag, "_busy"}, 32'(busy), 32'd1);
      if (server_ready) begin
        got = 1'b1;
        lat = cyc - 1;
      end
    end
    arbiter_req = 1'b0;
    wr_en       = 1'b0;
    check_eq({tag, "_seen"}, 32'(got), 32'd1);
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_l));
    check_eq({tag, "_data"}, 32'(server_data), 32'(exp_d));
    check_eq({tag, "_idle"}, 32'(busy), 32'd0);
    @(negedge clk);
    check_eq({tag, "_pulse"}, 32'(server_ready), 32'd0);
    check_eq({tag, "_hold"}, 32'(server_data), 32'(exp_d));
  endtask

  initial begin
    logic [7:0]  h;
    logic [15:0] d;
    int st;
    bit seen;

    repeat (3) @(negedge clk);
    check_eq("rst_data", 32'(server_data), 32'd0);
    check_eq("rst_ready", 32'(server_ready), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_perr", 32'(proto_err), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 4096; i++) load(12'(i), 16'($urandom));
    load({2'd1, 10'd5}, 16'h1234);
    load({2'd0, 10'd100}, 16'h0100);
    load({2'd0, 10'd101}, 16'h0200);
    load({2'd3, 10'd1023}, 16'h0400);
    load({2'd3, 10'd0}, 16'h0000);
    @(negedge clk);
    wr_en = 1'b0;

    txn("basic", 8'd1, 16'h0005, 0, 12'h0, 16'h0, 1'b0);
    txn("stall", 8'd1, 16'h0005, 2, {2'd2, 10'd77}, 16'hBEEF, 1'b0);
    txn("wrback", 8'd2, INTERP ? 16'(77 * 64) : 16'd77, 0, 12'h0, 16'h0, 1'b0);
    txn("badh", 8'd7, 16'h1234, 0, 12'h0, 16'h0, 1'b0);
    check_eq("perr_pre", 32'(proto_err), 32'd0);
    txn("drop", 8'd0, 16'h0009, 0, 12'h0, 16'h0, 1'b1);
    check_eq("perr_set", 32'(proto_err), 32'd1);

`ifdef RR_MEM_SERVER_INTERP_EN
    txn("interp_mid", 8'd0, 16'(100 * 64 + 32), 0, 12'h0, 16'h0, 1'b0);
    check_eq("interp_mid_val", 32'(server_data), 32'h0180);
    txn("interp_wrap", 8'd3, 16'(1023 * 64 + 16), 0, 12'h0, 16'h0, 1'b0);
    check_eq("interp_wrap_val", 32'(server_data), 32'h0300);
`endif

    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(0, 9) == 0) h = 8'($urandom_range(4, 255));
      else                           h = 8'($urandom_range(0, 3));
      d  = 16'($urandom);
      st = (int'(h) < NT) ? int'($urandom_range(0, 2)) : 0;
      txn($sformatf("rnd%0d", n), h, d, st, {2'(h[1:0] + 2'd1), 10'($urandom)}, 16'($urandom), 1'b0);
    end
    check_eq("perr_sticky", 32'(proto_err), 32'd1);

    @(negedge clk);
    arbiter_req = 1'b1;
    req_handle  = 8'd1;
    req_data    = 16'h0005;
    @(posedge clk);
    @(negedge clk);
    arbiter_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("mid_rst_data", 32'(server_data), 32'd0);
    check_eq("mid_rst_ready", 32'(server_ready), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_perr", 32'(proto_err), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (server_ready) seen = 1'b1;
    end
    check_eq("mid_rst_noresp", 32'(seen), 32'd0);
    txn("post_rst", 8'd1, 16'h0005, 0, 12'h0, 16'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_mem_server.md
# rr_mem_server

Responder end of the round-robin arbitration interface: accepts one arbitrated request at a time (request data and handle), performs a table lookup in an internal block RAM, and returns the result with a one-cycle ready pulse. It sits behind `rr_arbiter_handle`, serving shared coefficient and waveform tables to many pipeline clients. A loader-side write port fills the tables at runtime.

## Interface
- `req_data_width`, 16: width of the request word.
- `handle_width`, 8: width of the request handle; its low bits select the table.
- `server_data_width`, 16: width of a table entry and of the response; signed.
- `addr_width`, 10: index bits per table; each table holds 2^addr_width entries.
- `n_tables`, 4: number of tables, power of two; `tsel_width` = $clog2(n_tables).
- `frac_bits`, 6: fractional index bits, used only with interpolation; requires `addr_width` + `frac_bits` <= `req_data_width`.
- `mem_latency`, 1: RAM read latency in cycles, at least 1.
- `clk`  in  1  the single clock.
- `reset`  in  1  asynchronous, active-high.
- `arbiter_req`  in  1  one-cycle request strobe.
- `arbiter_req_data`  in  `req_data_width`  table index (and fraction).
- `arbiter_req_handle`  in  `handle_width`  table select.
- `server_data`  out  `server_data_width`  response data.
- `server_ready`  out  1  one-cycle response strobe.
- `wr_en`  in  1  loader write strobe.
- `wr_addr`  in  `tsel_width`+`addr_width`  write address as {table, index}.
- `wr_data`  in  `server_data_width`  write data.
- `busy`  out  1  high whenever the state is not IDLE.
- `proto_err`  out  1  sticky flag: a request arrived while busy.

## Operation
- Outputs at reset: `server_data` = 0, `server_ready` = 0, `busy` = 0, `proto_err` = 0. State is IDLE. RAM contents are not cleared.
- IDLE:
  - When `arbiter_req` is high, latch the data and the handle, then go to ISSUE_A.
  - If the handle is >= `n_tables`, set the result to 0 and go directly to RESP.
- ISSUE_A:
  - Drive the RAM read for {tsel, idx_a}, then go to WAIT (or to ISSUE_B when interpolation is enabled).
  - If `wr_en` is high in this cycle, the write wins. The state holds and the read is retried next cycle; each such cycle adds one cycle of latency.
- WAIT: count `mem_latency` cycles, capture RAM data, then go to RESP (or to CALC when interpolation is enabled).
- RESP:
  - Register `server_data` and pulse `server_ready` for exactly one cycle, then return to IDLE.
  - `server_data` holds its value until the next response.
- An `arbiter_req` seen outside IDLE is dropped and sets `proto_err`. Only reset clears `proto_err`.
- Writes are accepted in every state. A write to the entry being read returns either the old or the new value (RAM read-during-write behaviour); this case is not checked.
- Index without interpolation: `idx_a` = data[`addr_width`-1:0]. Upper bits are ignored.
- Reset asserted mid-transaction: the transaction is abandoned and no `server_ready` pulse is produced.

## Timing
- Request sampled at edge E0. `server_ready` is registered at edge E0 + L and is high for the following cycle.
- L = `mem_latency` + 2 without interpolation, L = `mem_latency` + 4 with it, plus 1 per write-stall cycle.
- Invalid handle: L = 1.
- The minimum L of 1 satisfies the arbiter's one-cycle guard, which ignores `server_ready` in the first WAIT cycle.
- Back-to-back operation: a new request is accepted at the first edge after RESP.

## Configuration
- `RR_MEM_SERVER_INTERP_EN`:
  - When defined, the request is interpreted as idx_a = data[`frac_bits` +: `addr_width`], frac = data[`frac_bits`-1:0], and idx_b = (idx_a + 1) mod 2^`addr_width`, wrapping within the same table.
  - Extra states: ISSUE_B issues the read of b one cycle after a (subject to the same write stall); CALC computes the result.
  - CALC: diff = b - a, signed, `server_data_width`+1 bits; prod = diff * frac, unsigned frac zero-extended; result = a + (prod >>> `frac_bits`), truncated to `server_data_width`.
  - When not defined, there are no ISSUE_B or CALC states, `frac_bits` is unused, and the entry is returned verbatim.

## Structure
- Shared package holds:
  - state encodings: IDLE, ISSUE_A, ISSUE_B, WAIT, CALC, RESP;
  - the request-word field offset helpers.
- One sub-module: `rr_mem_server_ram`, a simple dual-port inferred RAM (write port plus read port) with `mem_latency` output registers.

## Test plan
- Handle 1, data 0x0005, table 1 entry 5 = 0x1234, `mem_latency` 1, no interpolation -> `server_ready` pulse 3 cycles after the request edge, `server_data` 0x1234, `busy` back low the following cycle.
- `wr_en` asserted during ISSUE_A on every cycle for 2 cycles -> response delayed by 2 cycles with the correct data; the written entry reads back on the next request.
- Request with handle 7 (`n_tables` 4) -> `server_data` 0, `server_ready` 1 cycle after the request.
- Second `arbiter_req` during WAIT -> dropped, `proto_err` = 1, first response still correct; `proto_err` stays high until reset.
- Interpolation: a = 0x0100, b = 0x0200, frac = 32 of 64 -> 0x0180. Index 1023 with entry 0 = 0x0000 and entry 1023 = 0x0400, frac = 16 -> 0x0300 (wrap within the table).
- `reset` pulsed in WAIT -> no `server_ready`, all outputs 0; the next request is served normally.
